// File: rtl/cdc_sync_filter.sv
// -----------------------------------------------------------------------------
// cdc_sync_filter
//
// Multi-channel input synchronizer with a per-channel stability filter and
// change strobes. Each channel is brought into the clk domain through a
// SYNC_TIMES flop chain. The synchronized value must then hold for
// STABLE_CYCLES consecutive samples before it is accepted into data_out.
// A one-cycle changed pulse marks every accepted update.
//
// Ports
//   clk          in   1                    single clock, all logic on posedge
//   reset        in   1                    synchronous, active-high
//   data_in      in   CHANNELS*DATA_WIDTH  asynchronous inputs, channel n at
//                                          [n*DATA_WIDTH +: DATA_WIDTH]
//   data_out     out  CHANNELS*DATA_WIDTH  qualified values, registered
//   changed      out  CHANNELS             per-channel 1-cycle update pulse
//   stable       out  CHANNELS             candidate has met STABLE_CYCLES
//   any_changed  out  1                    registered OR of the changed pulses
// -----------------------------------------------------------------------------
module cdc_sync_filter #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    CHANNELS      = 4,
    parameter int                    SYNC_TIMES    = 3,
    parameter int                    STABLE_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]            changed,
    output logic [CHANNELS-1:0]            stable,
    output logic                           any_changed
);

    // Counter just wide enough to hold STABLE_CYCLES; it saturates there.
    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [CHANNELS-1:0] changed_d;
    logic                any_changed_d;
    logic                any_changed_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

        logic [DATA_WIDTH-1:0] sync_q [SYNC_TIMES];
        logic [DATA_WIDTH-1:0] sync_d [SYNC_TIMES];
        logic [DATA_WIDTH-1:0] samp;
        logic [DATA_WIDTH-1:0] cand_q;
        logic [DATA_WIDTH-1:0] cand_d;
        logic [DATA_WIDTH-1:0] out_q;
        logic [DATA_WIDTH-1:0] out_d;
        logic [CNT_W-1:0]      cnt_q;
        logic [CNT_W-1:0]      cnt_d;
        logic                  chg_q;
        logic                  chg_d;
        logic                  full;

        // Synchronizer chain: plain shift, first stage samples the async bus.
        always_comb begin
            sync_d[0] = data_in[ch*DATA_WIDTH +: DATA_WIDTH];
            for (int i = 1; i < SYNC_TIMES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < SYNC_TIMES; i++) begin
                    sync_q[i] <= RESET_VALUE;
                end
            end else begin
                for (int i = 0; i < SYNC_TIMES; i++) begin
                    sync_q[i] <= sync_d[i];
                end
            end
        end

        assign samp = sync_q[SYNC_TIMES-1];
        assign full = (cnt_q == CNT_FULL);

        // Stability filter. A new synchronized value restarts the count at 1;
        // an unchanged one counts up and saturates. Acceptance looks at the
        // current (pre-update) candidate and count, so a value is accepted one
        // cycle after its count reaches full.
        always_comb begin
            cand_d = cand_q;
            cnt_d  = cnt_q;
            out_d  = out_q;
            chg_d  = 1'b0;

            if (samp != cand_q) begin
                cand_d = samp;
                cnt_d  = CNT_ONE;
            end else if (cnt_q < CNT_FULL) begin
                cnt_d = cnt_q + CNT_ONE;
            end

            // A candidate equal to the current output (return-to-old) is
            // qualified silently: no update, no pulse.
            if (full && (cand_q != out_q)) begin
                out_d = cand_q;
                chg_d = 1'b1;
            end
        end

        // Reset loads a full count so the reset value reads as stable at once
        // and any half-qualified candidate is thrown away.
        always_ff @(posedge clk) begin
            if (reset) begin
                cand_q <= RESET_VALUE;
                cnt_q  <= CNT_FULL;
                out_q  <= RESET_VALUE;
                chg_q  <= 1'b0;
            end else begin
                cand_q <= cand_d;
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                chg_q  <= chg_d;
            end
        end

        assign data_out[ch*DATA_WIDTH +: DATA_WIDTH] = out_q;
        assign changed[ch]   = chg_q;
        assign stable[ch]    = full;
        assign changed_d[ch] = chg_d;
    end

    // OR of the next-state pulses so the summary lands in the same cycle as
    // the individual changed bits.
    always_comb begin
        any_changed_d = |changed_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            any_changed_q <= 1'b0;
        end else begin
            any_changed_q <= any_changed_d;
        end
    end

    assign any_changed = any_changed_q;

endmodule

// File: tb/tb_cdc_sync_filter.sv
module tb_cdc_sync_filter;

    localparam int         DW    = 8;
    localparam int         CH    = 4;
    localparam int         SYN   = 3;
    localparam int         STC   = 4;
    localparam logic [7:0] RV    = 8'h00;
    localparam int         MAXE  = 8192;

    logic            clk;
    logic            reset;
    logic [CH*DW-1:0] data_in;
    logic [CH*DW-1:0] data_out;
    logic [CH-1:0]    changed;
    logic [CH-1:0]    stable;
    logic             any_changed;

    logic [7:0] data_in6;
    logic [7:0] data_out6;
    logic [0:0] changed6;
    logic [0:0] stable6;
    logic       any_changed6;

    int compared   = 0;
    int mismatched = 0;

    cdc_sync_filter #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .SYNC_TIMES(SYN),
        .STABLE_CYCLES(STC), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
        .changed(changed), .stable(stable), .any_changed(any_changed)
    );

    cdc_sync_filter #(
        .DATA_WIDTH(8), .CHANNELS(1), .SYNC_TIMES(2),
        .STABLE_CYCLES(1), .RESET_VALUE(8'h00)
    ) dut6 (
        .clk(clk), .reset(reset), .data_in(data_in6), .data_out(data_out6),
        .changed(changed6), .stable(stable6), .any_changed(any_changed6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: history of every sampled input/reset, indexed by edge.
    // The synchronized value after edge j is the input sampled SYN-1 edges
    // earlier unless a reset intervened. The candidate after edge j is the
    // synchronized value after edge j-1, and a channel is stable when the
    // last STC candidates are all equal (everything at/before a reset counts
    // as RV).
    // ---------------------------------------------------------------------
    logic [CH*DW-1:0] din_h     [MAXE];
    int               lastrst_h [MAXE];
    int               e;
    bit               mvalid;
    logic [7:0]       m_out [CH];
    logic [CH-1:0]    m_chg;
    logic [CH-1:0]    m_stab;
    logic             m_any;

    function automatic logic [7:0] s_after(int c, int j);
        int m;
        m = j - SYN + 1;
        if (m <= lastrst_h[j]) return RV;
        return din_h[m][c*DW +: DW];
    endfunction

    function automatic logic [7:0] cand_val(int c, int j, int lr);
        if (j <= lr) return RV;
        return s_after(c, j - 1);
    endfunction

    function automatic bit stable_after(int c, int k);
        int         lr;
        logic [7:0] r;
        lr = lastrst_h[k];
        r  = cand_val(c, k, lr);
        for (int i = 1; i < STC; i++) begin
            if (cand_val(c, k - i, lr) != r) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] cv;
        e      = -1;
        mvalid = 1'b0;
        m_chg  = '0;
        m_stab = '0;
        m_any  = 1'b0;
        for (int c = 0; c < CH; c++) m_out[c] = RV;
        forever begin
            @(posedge clk);
            if (e < MAXE - 1) begin
                e++;
                din_h[e] = data_in;
                if (reset) lastrst_h[e] = e;
                else       lastrst_h[e] = (e > 0) ? lastrst_h[e-1] : -1;
                if (lastrst_h[e] >= 0) begin
                    if (reset) begin
                        for (int c = 0; c < CH; c++) m_out[c] = RV;
                        m_chg = '0;
                    end else begin
                        for (int c = 0; c < CH; c++) begin
                            cv = cand_val(c, e - 1, lastrst_h[e-1]);
                            if (stable_after(c, e - 1) && (cv != m_out[c])) begin
                                m_out[c] = cv;
                                m_chg[c] = 1'b1;
                            end else begin
                                m_chg[c] = 1'b0;
                            end
                        end
                    end
                    for (int c = 0; c < CH; c++) m_stab[c] = stable_after(c, e);
                    m_any  = |m_chg;
                    mvalid = 1'b1;
                end
            end else begin
                mvalid = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        logic [CH*DW-1:0] exp_do;
        forever begin
            @(negedge clk);
            if (mvalid) begin
                for (int c = 0; c < CH; c++) exp_do[c*DW +: DW] = m_out[c];
                check("model.data_out", 32'(data_out), 32'(exp_do));
                check("model.changed", 32'(changed), 32'(m_chg));
                check("model.stable", 32'(stable), 32'(m_stab));
                check("model.any_changed", 32'(any_changed), 32'(m_any));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed scenarios with literal expectations, then random traffic.
    // ---------------------------------------------------------------------
    initial begin
        int hold [CH];
        int lowcnt;
        bit found;

        // T1: reset for two edges with random inputs
        reset    = 1'b1;
        data_in  = $urandom;
        data_in6 = 8'($urandom);
        repeat (2) @(negedge clk);
        check("t1.data_out", 32'(data_out), 32'h0);
        check("t1.changed", 32'(changed), 32'h0);
        check("t1.stable", 32'(stable), 32'hF);
        check("t1.any_changed", 32'(any_changed), 32'h0);
        check("t1.data_out6", 32'(data_out6), 32'h0);
        reset    = 1'b0;
        data_in  = '0;
        data_in6 = 8'h00;
        repeat (8) @(negedge clk);

        // T6: SYNC_TIMES=2, STABLE_CYCLES=1 instance
        data_in6 = 8'h03;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6.data_out", 32'(data_out6), (k >= 3) ? 32'h3 : 32'h0);
            check("t6.changed", 32'(changed6), (k == 3) ? 32'h1 : 32'h0);
            check("t6.any_changed", 32'(any_changed6), (k == 3) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("t6.sat_data_out", 32'(data_out6), 32'h3);
            check("t6.sat_changed", 32'(changed6), 32'h0);
            check("t6.sat_stable", 32'(stable6), 32'h1);
        end

        // T2: latency on ch0
        data_in[7:0] = 8'h5A;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("t2.stable0", 32'(stable[0]), (k < 3 || k >= 6) ? 32'h1 : 32'h0);
            check("t2.data_out0", 32'(data_out[7:0]), (k >= 7) ? 32'h5A : 32'h0);
            check("t2.changed0", 32'(changed[0]), (k == 7) ? 32'h1 : 32'h0);
        end
        repeat (4) @(negedge clk);

        // T3: 3-cycle glitch on ch1
        data_in[15:8] = 8'hFF;
        repeat (3) @(negedge clk);
        data_in[15:8] = 8'h00;
        lowcnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!stable[1]) lowcnt++;
            check("t3.data_out1", 32'(data_out[15:8]), 32'h0);
            check("t3.changed1", 32'(changed[1]), 32'h0);
        end
        check("t3.stable1_low_cycles", 32'(lowcnt), 32'd6);
        check("t3.stable1_final", 32'(stable[1]), 32'h1);

        // T4: ch0 and ch3 change together
        data_in[7:0]   = 8'h11;
        data_in[31:24] = 8'h33;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (changed != '0) found = 1'b1;
        end
        check("t4.pulse_seen", 32'(found), 32'h1);
        check("t4.changed", 32'(changed), 32'h9);
        check("t4.any_changed", 32'(any_changed), 32'h1);
        check("t4.data_out", 32'(data_out), 32'h3300_0011);
        repeat (4) @(negedge clk);

        // T5: reset in the middle of qualifying 0x77 on ch2
        data_in[23:16] = 8'h77;
        for (int k = 0; k < 5; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5.rst_data_out2", 32'(data_out[23:16]), 32'h0);
        check("t5.rst_changed", 32'(changed), 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5.data_out2", 32'(data_out[23:16]), (k >= 7) ? 32'h77 : 32'h0);
            check("t5.changed2", 32'(changed[2]), (k == 7) ? 32'h1 : 32'h0);
        end

        // Random traffic: per-channel values held for random durations,
        // drawn from a small pool so return-to-old cases occur.
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    case ($urandom_range(0, 3))
                        0:       data_in[c*DW +: DW] = 8'h00;
                        1:       data_in[c*DW +: DW] = 8'h5A;
                        2:       data_in[c*DW +: DW] = 8'hA5;
                        default: data_in[c*DW +: DW] = 8'($urandom);
                    endcase
                    hold[c] = $urandom_range(1, 12);
                end
                hold[c]--;
            end
            reset = ($urandom_range(0, 249) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
